// File: rtl/cdb_pkg.sv
// Shared types and defaults for the common-data-bus broadcaster.
package cdb_pkg;
  localparam int CDB_TAG_W  = 7;
  localparam int CDB_DATA_W = 32;
  localparam logic [CDB_TAG_W-1:0] CDB_NULL_TAG = {CDB_TAG_W{1'b0}};

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_pkt_t;
endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source synchronous FIFO of result packets; flush clears it and overrides push/pop.
module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter type pkt_t = cdb_pkt_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic push_i,
  input  logic pop_i,
  input  pkt_t wdata_i,
  output pkt_t rdata_o,
  output logic full_o,
  output logic empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  pkt_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign do_push_s = push_i & ~full_o & ~flush;
  assign do_pop_s  = pop_i & ~empty_o & ~flush;
  assign rdata_o   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/cdb_broadcaster.sv
// Round-robin arbiter driving the common data bus from NUM_SRC buffered result sources.
// Optional CDB_BYPASS_EN lets a result from an empty source skip its FIFO when granted.
module cdb_broadcaster
  import cdb_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DATA_W     = CDB_DATA_W,
  parameter int TAG_W      = CDB_TAG_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [DATA_W-1:0]         ALU_result,
  output logic [TAG_W-1:0]          ALU_result_dest,
  output logic                      ALU_result_valid
);
  localparam int RW = $clog2(NUM_SRC);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } slot_t;

  slot_t              in_pkt_s   [NUM_SRC];
  slot_t              head_pkt_s [NUM_SRC];
  logic [NUM_SRC-1:0] full_s, empty_s, xfer_s, cand_s, push_s, pop_s, byp_gnt_s;
  logic [RW-1:0]      grant_s, rr_d, rr_q;
  logic               grant_vld_s;
  slot_t              sel_pkt_s;
  logic [DATA_W-1:0]  result_q;
  logic [TAG_W-1:0]   dest_q;
  logic               valid_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic tag_live_s;
    logic granted_s;

    assign in_pkt_s[i]   = '{tag: src_tag[i*TAG_W +: TAG_W], data: src_data[i*DATA_W +: DATA_W]};
    assign tag_live_s    = (in_pkt_s[i].tag != CDB_NULL_TAG[TAG_W-1:0]);
    assign src_ready[i]  = ~full_s[i];
    assign xfer_s[i]     = src_valid[i] & src_ready[i];
    assign granted_s     = grant_vld_s & (grant_s == RW'(i));
`ifdef CDB_BYPASS_EN
    assign cand_s[i]     = ~empty_s[i] | (xfer_s[i] & tag_live_s);
`else
    assign cand_s[i]     = ~empty_s[i];
`endif
    // A granted empty source can only be a bypass; its input is consumed, not stored.
    assign byp_gnt_s[i]  = granted_s & empty_s[i];
    assign pop_s[i]      = granted_s & ~empty_s[i];
    assign push_s[i]     = xfer_s[i] & tag_live_s & ~byp_gnt_s[i];

    cdb_src_fifo #(.pkt_t(slot_t), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .push_i  (push_s[i]),
      .pop_i   (pop_s[i]),
      .wdata_i (in_pkt_s[i]),
      .rdata_o (head_pkt_s[i]),
      .full_o  (full_s[i]),
      .empty_o (empty_s[i])
    );
  end

  // Scan from the far end so the candidate closest to rr_q is the one that sticks.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_s     = rr_q;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      int idx;
      idx         = (int'(rr_q) + k) % NUM_SRC;
      grant_s     = cand_s[idx] ? RW'(idx) : grant_s;
      grant_vld_s = grant_vld_s | cand_s[idx];
    end
  end

  // Next round-robin start is one past the winner.
  always_comb begin
    rr_d = rr_q;
    if (grant_vld_s) begin
      rr_d = (grant_s == RW'(NUM_SRC - 1)) ? {RW{1'b0}} : grant_s + RW'(1);
    end else begin
      rr_d = rr_q;
    end
  end

  // Packet loaded into the bus registers for the winning source.
  always_comb begin
    sel_pkt_s = head_pkt_s[grant_s];
`ifdef CDB_BYPASS_EN
    if (empty_s[grant_s]) begin
      sel_pkt_s = in_pkt_s[grant_s];
    end else begin
      sel_pkt_s = head_pkt_s[grant_s];
    end
`endif
  end

  // Bus output registers and arbitration pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q     <= {RW{1'b0}};
      result_q <= {DATA_W{1'b0}};
      dest_q   <= {TAG_W{1'b0}};
      valid_q  <= 1'b0;
    end else if (flush) begin
      rr_q    <= {RW{1'b0}};
      valid_q <= 1'b0;
    end else begin
      valid_q <= grant_vld_s;
      rr_q    <= rr_d;
      if (grant_vld_s) begin
        result_q <= sel_pkt_s.data;
        dest_q   <= sel_pkt_s.tag;
      end
    end
  end

  assign ALU_result       = result_q;
  assign ALU_result_dest  = dest_q;
  assign ALU_result_valid = valid_q;
endmodule
